// File: rtl/binary_search_pro.sv
`default_nettype none
// ============================================================================
//  Module      : binary_search_pro
//  Description : Table lookup accelerator. It holds a sorted table in a
//                synchronous-read RAM that is loaded through a write port.
//                Each search is a multi-cycle, half-open binary search in
//                one of two modes: lower bound (first element >= target) or
//                upper bound (first element > target).
//
//  Ports       : clk       - clock; all logic runs on the rising edge
//                rst       - synchronous active-high reset
//                wr_en     - table write strobe (ignored while busy)
//                wr_addr   - table write address
//                wr_data   - table write data
//                start     - begin a search (sampled in IDLE only)
//                mode      - 0 = lower bound, 1 = upper bound
//                target    - search key
//                busy      - search in progress
//                done      - one-cycle result strobe
//                out       - result index (0 when past_end)
//                found     - exact match exists
//                past_end  - no qualifying element in the table
//
//  Revision    : 1.0 - initial release
// ============================================================================
module binary_search_pro #(
    parameter int NUMBER_SIZE = 32,
    parameter int INDEX_SIZE  = 5,
    parameter int MEMORY_SIZE = 32,
    parameter int SIGNED_CMP  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [INDEX_SIZE-1:0]  wr_addr,
    input  logic [NUMBER_SIZE-1:0] wr_data,
    input  logic                   start,
    input  logic                   mode,
    input  logic [NUMBER_SIZE-1:0] target,
    output logic                   busy,
    output logic                   done,
    output logic [INDEX_SIZE-1:0]  out,
    output logic                   found,
    output logic                   past_end
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_FETCH   = 2'd1;
    localparam logic [1:0] c_COMPARE = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam logic [INDEX_SIZE:0] c_MEM_SIZE = (INDEX_SIZE+1)'(MEMORY_SIZE);
    localparam logic [INDEX_SIZE:0] c_ONE      = (INDEX_SIZE+1)'(1);

    logic [NUMBER_SIZE-1:0] r_mem [MEMORY_SIZE];
    logic [NUMBER_SIZE-1:0] r_rd_data;
    logic [NUMBER_SIZE-1:0] r_target;
    logic [1:0]             r_state;
    // lo/hi carry one extra bit so hi can equal MEMORY_SIZE and lo+hi
    // never wraps.
    logic [INDEX_SIZE:0]    r_lo;
    logic [INDEX_SIZE:0]    r_hi;
    logic [INDEX_SIZE:0]    r_mid;
    logic                   r_eq_lo;
    logic                   r_eq_hi;
    logic                   r_mode;

    logic                   w_wr_ok;
    logic [INDEX_SIZE:0]    w_sum;
    logic [INDEX_SIZE:0]    w_mid;
    logic                   w_lt;
    logic                   w_eq;
    logic                   w_take;
    logic [INDEX_SIZE:0]    w_new_lo;
    logic [INDEX_SIZE:0]    w_new_hi;
    logic                   w_past_end;

    // Writes are refused during a search so the table stays stable while
    // the engine walks it; a write in the IDLE start cycle commits before
    // the first RAM read.
    assign w_wr_ok = wr_en && !busy && ({1'b0, wr_addr} < c_MEM_SIZE);

    assign w_sum = r_lo + r_hi;
    assign w_mid = w_sum >> 1;

    generate
        if (SIGNED_CMP != 0) begin : g_signed_cmp
            assign w_lt = $signed(r_rd_data) < $signed(r_target);
        end else begin : g_unsigned_cmp
            assign w_lt = r_rd_data < r_target;
        end
    endgenerate

    assign w_eq       = (r_rd_data == r_target);
    // Upper bound also moves past elements equal to the target.
    assign w_take     = r_mode ? (w_lt | w_eq) : w_lt;
    assign w_new_lo   = w_take ? (r_mid + c_ONE) : r_lo;
    assign w_new_hi   = w_take ? r_hi : r_mid;
    assign w_past_end = (r_lo == c_MEM_SIZE);

    // Table RAM: write port plus a registered read issued from FETCH.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (r_state == c_FETCH) begin
            r_rd_data <= r_mem[w_mid[INDEX_SIZE-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_mid    <= '0;
            r_eq_lo  <= 1'b0;
            r_eq_hi  <= 1'b0;
            r_mode   <= 1'b0;
            r_target <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            found    <= 1'b0;
            past_end <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_target <= target;
                        r_mode   <= mode;
                        r_lo     <= '0;
                        r_hi     <= c_MEM_SIZE;
                        r_eq_lo  <= 1'b0;
                        r_eq_hi  <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    r_mid   <= w_mid;
                    r_state <= c_COMPARE;
                end
                c_COMPARE: begin
                    r_lo <= w_new_lo;
                    r_hi <= w_new_hi;
                    // Each flag remembers whether the element that last
                    // moved that bound equalled the target.
                    if (w_take) begin
                        r_eq_lo <= w_eq;
                    end else begin
                        r_eq_hi <= w_eq;
                    end
                    r_state <= (w_new_lo == w_new_hi) ? c_DONE : c_FETCH;
                end
                c_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    past_end <= w_past_end;
                    out      <= w_past_end ? '0 : r_lo[INDEX_SIZE-1:0];
                    found    <= r_mode ? r_eq_lo : (r_eq_hi & ~w_past_end);
                    r_state  <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_binary_search_pro.sv
`default_nettype none
// ============================================================================
//  Module      : tb_binary_search_pro
//  Description : Directed testbench for binary_search_pro. An unsigned and a
//                signed instance share all inputs; each test task drives its
//                scenario and compares results against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_search_pro;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        mode;
    logic [31:0] target;

    logic        busy, done, found, past_end;
    logic [4:0]  out;
    logic        s_busy, s_done, s_found, s_past_end;
    logic [4:0]  s_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    binary_search_pro #(
        .NUMBER_SIZE(32), .INDEX_SIZE(5), .MEMORY_SIZE(32), .SIGNED_CMP(0)
    ) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .mode(mode), .target(target),
        .busy(busy), .done(done), .out(out), .found(found), .past_end(past_end)
    );

    binary_search_pro #(
        .NUMBER_SIZE(32), .INDEX_SIZE(5), .MEMORY_SIZE(32), .SIGNED_CMP(1)
    ) u_dut_s (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .mode(mode), .target(target),
        .busy(s_busy), .done(s_done), .out(s_out), .found(s_found), .past_end(s_past_end)
    );

    typedef struct {
        logic        m;
        logic [31:0] t;
        int          e_out;
        logic        e_found;
        logic        e_pe;
    } vec_t;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Runs one search on the selected instance. The start edge counts as
    // edge 1; r_edges is the edge after which done was seen (40 = timeout).
    task automatic run_search(input logic sel, input logic m, input logic [31:0] t,
                              output int r_out, output logic r_found,
                              output logic r_pe, output int r_edges,
                              output logic r_one);
        start  = 1'b1;
        mode   = m;
        target = t;
        tick();
        start   = 1'b0;
        wr_en   = 1'b0;
        r_edges = 1;
        while (!(sel ? s_done : done) && r_edges < 40) begin
            tick();
            r_edges++;
        end
        r_out   = sel ? int'(s_out) : int'(out);
        r_found = sel ? s_found : found;
        r_pe    = sel ? s_past_end : past_end;
        tick();
        // done must drop after one cycle while the result holds.
        r_one = !(sel ? s_done : done) &&
                ((sel ? int'(s_out) : int'(out)) == r_out) &&
                ((sel ? s_found : found) == r_found);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; mode = 1'b0; target = '0;
        repeat (3) tick();
        checks += 5;
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (out !== 5'd0)      begin errors++; $display("FAIL reset_out: got %0d expected 0", out); end
        if (found !== 1'b0)    begin errors++; $display("FAIL reset_found: got %b expected 0", found); end
        if (past_end !== 1'b0) begin errors++; $display("FAIL reset_past_end: got %b expected 0", past_end); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        for (int i = 0; i < 32; i++) do_write(i, 32'(2 * i));
    endtask

    task automatic test_timing();
        int o, e; logic f, p, one;
        // target 15: hi=16, hi=8, lo=5, lo=7, lo=8 -> 5 iterations -> edge 12.
        run_search(1'b0, 1'b0, 32'd15, o, f, p, e, one);
        checks += 5;
        if (o !== 8)    begin errors++; $display("FAIL lb15_out: got %0d expected 8", o); end
        if (f !== 1'b0) begin errors++; $display("FAIL lb15_found: got %b expected 0", f); end
        if (p !== 1'b0) begin errors++; $display("FAIL lb15_past_end: got %b expected 0", p); end
        if (e !== 12)   begin errors++; $display("FAIL lb15_latency: got %0d edges expected 12", e); end
        if (!one)       begin errors++; $display("FAIL lb15_done_width: got done>1 cycle or result changed, expected single pulse"); end
    endtask

    task automatic test_lookup();
        vec_t v[8];
        int o, e; logic f, p, one;
        v[0] = '{1'b0, 32'd16,  8,  1'b1, 1'b0};
        v[1] = '{1'b1, 32'd16,  9,  1'b1, 1'b0};
        v[2] = '{1'b0, 32'd100, 0,  1'b0, 1'b1};
        v[3] = '{1'b1, 32'd100, 0,  1'b0, 1'b1};
        v[4] = '{1'b0, 32'd0,   0,  1'b1, 1'b0};
        v[5] = '{1'b1, 32'd0,   1,  1'b1, 1'b0};
        v[6] = '{1'b0, 32'd62,  31, 1'b1, 1'b0};
        v[7] = '{1'b1, 32'd62,  0,  1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            run_search(1'b0, v[i].m, v[i].t, o, f, p, e, one);
            checks += 4;
            if (o !== v[i].e_out)   begin errors++; $display("FAIL lookup%0d_out: got %0d expected %0d", i, o, v[i].e_out); end
            if (f !== v[i].e_found) begin errors++; $display("FAIL lookup%0d_found: got %b expected %b", i, f, v[i].e_found); end
            if (p !== v[i].e_pe)    begin errors++; $display("FAIL lookup%0d_past_end: got %b expected %b", i, p, v[i].e_pe); end
            if (e < 12 || e > 14)   begin errors++; $display("FAIL lookup%0d_latency: got %0d edges expected 12..14", i, e); end
        end
    endtask

    task automatic test_duplicates();
        int o, e; logic f, p, one;
        for (int i = 10; i <= 13; i++) do_write(i, 32'd20);
        run_search(1'b0, 1'b0, 32'd20, o, f, p, e, one);
        checks += 2;
        if (o !== 10)   begin errors++; $display("FAIL dup_lb_out: got %0d expected 10", o); end
        if (f !== 1'b1) begin errors++; $display("FAIL dup_lb_found: got %b expected 1", f); end
        run_search(1'b0, 1'b1, 32'd20, o, f, p, e, one);
        checks += 2;
        if (o !== 14)   begin errors++; $display("FAIL dup_ub_out: got %0d expected 14", o); end
        if (f !== 1'b1) begin errors++; $display("FAIL dup_ub_found: got %b expected 1", f); end
    endtask

    task automatic test_busy_ignore();
        int o, e; logic f, p, one;
        start = 1'b1; mode = 1'b0; target = 32'd30;
        tick();
        start = 1'b0;
        e = 1;
        // Write and restart attempts with a different key/mode while busy.
        wr_en = 1'b1; wr_addr = 5'd15; wr_data = 32'd0;
        start = 1'b1; mode = 1'b1; target = 32'd0;
        repeat (3) begin tick(); e++; end
        checks += 1;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_flag: got %b expected 1", busy); end
        wr_en = 1'b0; start = 1'b0;
        while (!done && e < 40) begin tick(); e++; end
        checks += 3;
        if (e >= 40)            begin errors++; $display("FAIL busy_timeout: got no done expected done"); end
        if (out !== 5'd15)      begin errors++; $display("FAIL busy_out: got %0d expected 15", out); end
        if (found !== 1'b1)     begin errors++; $display("FAIL busy_found: got %b expected 1", found); end
        tick();
        run_search(1'b0, 1'b0, 32'd30, o, f, p, e, one);
        checks += 2;
        if (o !== 15)   begin errors++; $display("FAIL busy_table_out: got %0d expected 15", o); end
        if (f !== 1'b1) begin errors++; $display("FAIL busy_table_found: got %b expected 1", f); end
    endtask

    task automatic test_write_with_start();
        int o, e; logic f, p, one;
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'd41;
        run_search(1'b0, 1'b0, 32'd41, o, f, p, e, one);
        checks += 2;
        if (o !== 20)   begin errors++; $display("FAIL wr_start_out: got %0d expected 20", o); end
        if (f !== 1'b1) begin errors++; $display("FAIL wr_start_found: got %b expected 1", f); end
    endtask

    task automatic test_reset_mid();
        int o, e; logic f, p, one;
        // Prior search leaves out=14, found=1 so clearing is observable.
        run_search(1'b0, 1'b1, 32'd20, o, f, p, e, one);
        start = 1'b1; mode = 1'b0; target = 32'd16;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks += 5;
        if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (done !== 1'b0)     begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        if (out !== 5'd0)      begin errors++; $display("FAIL midrst_out: got %0d expected 0", out); end
        if (found !== 1'b0)    begin errors++; $display("FAIL midrst_found: got %b expected 0", found); end
        if (past_end !== 1'b0) begin errors++; $display("FAIL midrst_past_end: got %b expected 0", past_end); end
        rst = 1'b0;
        tick();
        run_search(1'b0, 1'b0, 32'd16, o, f, p, e, one);
        checks += 2;
        if (o !== 8)    begin errors++; $display("FAIL after_rst_out: got %0d expected 8", o); end
        if (f !== 1'b1) begin errors++; $display("FAIL after_rst_found: got %b expected 1", f); end
    endtask

    task automatic test_signed();
        vec_t v[4];
        int o, e; logic f, p, one;
        for (int i = 0; i < 32; i++) do_write(i, 32'(i - 16));
        v[0] = '{1'b0, 32'hFFFF_FFFD, 13, 1'b1, 1'b0};  // -3
        v[1] = '{1'b1, 32'hFFFF_FFFD, 14, 1'b1, 1'b0};  // -3
        v[2] = '{1'b0, 32'hFFFF_FF9C, 0,  1'b0, 1'b0};  // -100
        v[3] = '{1'b0, 32'd20,        0,  1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_search(1'b1, v[i].m, v[i].t, o, f, p, e, one);
            checks += 3;
            if (o !== v[i].e_out)   begin errors++; $display("FAIL signed%0d_out: got %0d expected %0d", i, o, v[i].e_out); end
            if (f !== v[i].e_found) begin errors++; $display("FAIL signed%0d_found: got %b expected %b", i, f, v[i].e_found); end
            if (p !== v[i].e_pe)    begin errors++; $display("FAIL signed%0d_past_end: got %b expected %b", i, p, v[i].e_pe); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_timing();
        test_lookup();
        test_duplicates();
        test_busy_ignore();
        test_write_with_start();
        test_reset_mid();
        test_signed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
